// File: rtl/cpsd_pkg.sv
// Shared types and defaults for the cpsd beat scheduler.
// Holds the FSM encoding, classification codes and default parameter values.
package cpsd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_PEAK    = 2'd2,
        ST_REFRACT = 2'd3
    } state_e;

    localparam logic [1:0] CLS_NONE   = 2'd0;
    localparam logic [1:0] CLS_NORMAL = 2'd1;
    localparam logic [1:0] CLS_AF     = 2'd2;
    localparam logic [1:0] CLS_VF     = 2'd3;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_REFRACT    = 50;
    localparam int DEF_TIMEOUT    = 420;
    localparam int DEF_INIT_MAX   = 100;
    localparam int DEF_PEAK_FLOOR = -100;
    localparam int DEF_THR_SHIFT  = 1;

    // VF outranks AF, which outranks normal.
    function automatic logic [1:0] cls_encode(input logic normal, input logic af, input logic vf);
        logic [1:0] code;
        code = CLS_NONE;
        if (vf)
            code = CLS_VF;
        else if (af)
            code = CLS_AF;
        else if (normal)
            code = CLS_NORMAL;
        return code;
    endfunction

endpackage

// File: rtl/cpsd_peak_track.sv
// Signed running-peak register for the beat scheduler.
// clear restarts from the floor, load forces a value, track keeps the larger value.
module cpsd_peak_track
    import cpsd_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PEAK_FLOOR = DEF_PEAK_FLOOR
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         clear,
    input  logic                         load,
    input  logic                         track,
    input  logic signed [DATA_WIDTH-1:0] din,
    output logic signed [DATA_WIDTH-1:0] peak
);

    localparam logic signed [DATA_WIDTH-1:0] FLOOR = DATA_WIDTH'(PEAK_FLOOR);

    logic signed [DATA_WIDTH-1:0] peak_q, peak_d;

    always_comb begin
        peak_d = peak_q;
        if (clear)
            peak_d = FLOOR;
        else if (load)
            peak_d = din;
        else if (track && (din > peak_q))
            peak_d = din;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            peak_q <= FLOOR;
        else
            peak_q <= peak_d;
    end

    assign peak = peak_q;

endmodule

// File: rtl/cpsd_beat_sched.sv
// R-peak beat scheduler feeding cpsd_top: drives start/qrs/max and captures
// the per-beat class verdict and RR interval. All outputs are registered.
module cpsd_beat_sched
    import cpsd_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int REFRACT    = DEF_REFRACT,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int INIT_MAX   = DEF_INIT_MAX,
    parameter int PEAK_FLOOR = DEF_PEAK_FLOOR,
    parameter int THR_SHIFT  = DEF_THR_SHIFT
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          en,
    input  logic                          sample_valid,
    input  logic signed [DATA_WIDTH-1:0]  xin,
    input  logic                          cls_normal,
    input  logic                          cls_af,
    input  logic                          cls_vf,
    output logic                          start,
    output logic                          qrs,
    output logic signed [DATA_WIDTH-1:0]  max,
    output logic [$clog2(TIMEOUT+1)-1:0]  rr_interval,
    output logic [1:0]                    class_code,
    output logic                          class_valid,
    output logic                          missed_beat
);

    localparam int RRW  = $clog2(TIMEOUT + 1);
    localparam int REFW = (REFRACT > 1) ? $clog2(REFRACT) : 1;

    localparam logic [RRW-1:0]               RR_MAX   = RRW'(TIMEOUT);
    localparam logic [RRW-1:0]               RR_LAST  = RRW'(TIMEOUT - 1);
    localparam logic [REFW-1:0]              REF_LOAD = REFW'(REFRACT - 1);
    localparam logic signed [DATA_WIDTH-1:0] MAX_INIT = DATA_WIDTH'(INIT_MAX);

    state_e                       state_q, state_d;
    logic [RRW-1:0]               rr_cnt_q, rr_cnt_d, rr_inc;
    logic [REFW-1:0]              ref_cnt_q, ref_cnt_d;
    logic signed [DATA_WIDTH-1:0] max_q, max_d;
    logic [RRW-1:0]               rr_interval_q, rr_interval_d;
    logic [1:0]                   class_code_q, class_code_d;
    logic                         start_q, start_d;
    logic                         qrs_q, qrs_d;
    logic                         missed_q, missed_d;

    logic                         pk_clear, pk_load, pk_track;
    logic signed [DATA_WIDTH-1:0] peak, peak_upd, thr;
    logic                         timeout, beat, forced;

    cpsd_peak_track #(
        .DATA_WIDTH (DATA_WIDTH),
        .PEAK_FLOOR (PEAK_FLOOR)
    ) u_peak (
        .clk   (clk),
        .rstn  (rstn),
        .clear (pk_clear),
        .load  (pk_load),
        .track (pk_track),
        .din   (xin),
        .peak  (peak)
    );

    assign thr      = max_q >>> THR_SHIFT;
    assign rr_inc   = (rr_cnt_q >= RR_MAX) ? RR_MAX : rr_cnt_q + RRW'(1);
    assign timeout  = (rr_cnt_q >= RR_LAST);
    // A beat forced by timeout reports the peak including the current sample.
    assign peak_upd = (xin > peak) ? xin : peak;

    always_comb begin
        state_d       = state_q;
        rr_cnt_d      = rr_cnt_q;
        ref_cnt_d     = ref_cnt_q;
        max_d         = max_q;
        rr_interval_d = rr_interval_q;
        class_code_d  = class_code_q;
        qrs_d         = 1'b0;
        missed_d      = 1'b0;
        pk_clear      = 1'b0;
        pk_load       = 1'b0;
        pk_track      = 1'b0;
        beat          = 1'b0;
        forced        = 1'b0;

        if (!en) begin
            state_d  = ST_IDLE;
            rr_cnt_d = '0;
            pk_clear = 1'b1;
        end else if (state_q == ST_IDLE) begin
            state_d = ST_ARMED;
        end else if (sample_valid) begin
            rr_cnt_d = rr_inc;
            case (state_q)
                ST_ARMED: begin
                    if (xin > thr) begin
                        state_d = ST_PEAK;
                        pk_load = 1'b1;
                    end else begin
                        pk_track = 1'b1;
                        if (timeout) begin
                            beat   = 1'b1;
                            forced = 1'b1;
                        end
                    end
                end
                ST_PEAK: begin
                    if ((xin < peak) || timeout)
                        beat = 1'b1;
                    else
                        pk_track = 1'b1;
                end
                ST_REFRACT: begin
                    pk_track  = 1'b1;
                    ref_cnt_d = ref_cnt_q - REFW'(1);
                    if (ref_cnt_q == '0)
                        state_d = ST_ARMED;
                end
                default: state_d = ST_IDLE;
            endcase

            if (beat) begin
                qrs_d         = 1'b1;
                missed_d      = forced;
                max_d         = peak_upd;
                rr_interval_d = rr_inc;
                rr_cnt_d      = '0;
                pk_clear      = 1'b1;
                ref_cnt_d     = REF_LOAD;
                state_d       = ST_REFRACT;
                class_code_d  = cls_encode(cls_normal, cls_af, cls_vf);
            end
        end

        start_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_IDLE;
            rr_cnt_q      <= '0;
            ref_cnt_q     <= '0;
            max_q         <= MAX_INIT;
            rr_interval_q <= '0;
            class_code_q  <= CLS_NONE;
            start_q       <= 1'b0;
            qrs_q         <= 1'b0;
            missed_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_cnt_q      <= rr_cnt_d;
            ref_cnt_q     <= ref_cnt_d;
            max_q         <= max_d;
            rr_interval_q <= rr_interval_d;
            class_code_q  <= class_code_d;
            start_q       <= start_d;
            qrs_q         <= qrs_d;
            missed_q      <= missed_d;
        end
    end

    assign start       = start_q;
    assign qrs         = qrs_q;
    assign class_valid = qrs_q;
    assign missed_beat = missed_q;
    assign max         = max_q;
    assign rr_interval = rr_interval_q;
    assign class_code  = class_code_q;

endmodule

// File: tb/tb_cpsd_beat_sched.sv
// Bench for cpsd_beat_sched: directed scenarios plus random traffic, every
// cycle compared against a sample-level behavioural model of the scheduler.
module tb_cpsd_beat_sched;

    localparam int DW         = 16;
    localparam int REFRACT    = 50;
    localparam int TIMEOUT    = 420;
    localparam int INIT_MAX   = 100;
    localparam int PEAK_FLOOR = -100;

    localparam int M_IDLE = 0, M_ARMED = 1, M_PEAK = 2, M_REFR = 3;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic en = 1'b0, sample_valid = 1'b0;
    logic cls_normal = 1'b0, cls_af = 1'b0, cls_vf = 1'b0;
    logic signed [DW-1:0] xin = '0;
    logic start, qrs, class_valid, missed_beat;
    logic signed [DW-1:0] max;
    logic [8:0] rr_interval;
    logic [1:0] class_code;

    int nchk = 0, nerr = 0;

    // model state: mode, samples since last beat, refractory samples left
    int m_mode, m_rr, m_ref, m_peak, m_max, m_rri, m_cls;
    int e_start, e_qrs, e_miss;

    // beat record for directed scenarios
    int sidx, q_count, q_idx, q_max, q_rr, q_miss, q_cls;

    cpsd_beat_sched dut (
        .clk          (clk),
        .rstn         (rstn),
        .en           (en),
        .sample_valid (sample_valid),
        .xin          (xin),
        .cls_normal   (cls_normal),
        .cls_af       (cls_af),
        .cls_vf       (cls_vf),
        .start        (start),
        .qrs          (qrs),
        .max          (max),
        .rr_interval  (rr_interval),
        .class_code   (class_code),
        .class_valid  (class_valid),
        .missed_beat  (missed_beat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            if (nerr <= 40)
                $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_rr = 0; m_ref = 0; m_peak = PEAK_FLOOR;
        m_max = INIT_MAX; m_rri = 0; m_cls = 0;
        e_start = 0; e_qrs = 0; e_miss = 0;
    endtask

    // One clock of the scheduler described sample by sample.
    task automatic model_step(input bit e, input bit v, input int x, input bit n, input bit a, input bit f);
        int best, done;
        bit fire, forced;
        fire = 0; forced = 0;
        e_qrs = 0; e_miss = 0;
        if (!e) begin
            m_mode = M_IDLE; m_rr = 0; m_peak = PEAK_FLOOR;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_ARMED;
        end else if (v) begin
            best = (x > m_peak) ? x : m_peak;
            done = m_rr + 1;                       // samples since last beat incl. this one
            if (m_mode == M_ARMED) begin
                if (x > (m_max >>> 1)) begin
                    m_mode = M_PEAK; m_peak = x;
                end else begin
                    m_peak = best;
                    if (done >= TIMEOUT) begin fire = 1; forced = 1; end
                end
            end else if (m_mode == M_PEAK) begin
                if (x < m_peak || done >= TIMEOUT) fire = 1;
                else m_peak = x;
            end else begin
                m_peak = best;
                if (m_ref == 0) m_mode = M_ARMED;
                else m_ref = m_ref - 1;
            end
            m_rr = (done > TIMEOUT) ? TIMEOUT : done;
            if (fire) begin
                e_qrs = 1; e_miss = forced;
                m_max = best; m_rri = m_rr; m_rr = 0;
                m_peak = PEAK_FLOOR; m_ref = REFRACT - 1; m_mode = M_REFR;
                m_cls = f ? 3 : (a ? 2 : (n ? 1 : 0));
            end
        end
        e_start = (m_mode != M_IDLE);
    endtask

    task automatic compare();
        chk("start", int'(start), e_start);
        chk("qrs", int'(qrs), e_qrs);
        chk("class_valid", int'(class_valid), e_qrs);
        chk("missed_beat", int'(missed_beat), e_miss);
        chk("max", int'($signed(max)), m_max);
        chk("rr_interval", int'(rr_interval), m_rri);
        chk("class_code", int'(class_code), m_cls);
    endtask

    task automatic step(input bit e, input bit v, input int x, input bit n, input bit a, input bit f);
        en = e; sample_valid = v; xin = DW'(x);
        cls_normal = n; cls_af = a; cls_vf = f;
        @(posedge clk);
        model_step(e, v, x, n, a, f);
        @(negedge clk);
        compare();
        if (qrs) begin
            q_count++;
            if (q_count == 1) begin
                q_idx = sidx; q_max = int'($signed(max)); q_rr = int'(rr_interval);
                q_miss = int'(missed_beat); q_cls = int'(class_code);
            end
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0; en = 1'b0; sample_valid = 1'b0;
        model_reset();
        #1 compare();
        @(negedge clk);
        rstn = 1'b1;
        q_count = 0; q_idx = -1;
    endtask

    function automatic int tri_pulse(input int i, input int s, input int amp);
        int d;
        d = i - s - 5;
        if (d < 0) d = -d;
        if (i < s || i > s + 10) return 0;
        return amp - (amp / 5) * d;
    endfunction

    initial begin
        int pp, pamp, pw, en_hold, x;
        bit e, v;
        model_reset();
        @(negedge clk);
        compare();
        do_reset();

        // 1: single triangle pulse at sample 20
        step(1, 0, 0, 0, 0, 0);
        chk("t1_start_after_en", int'(start), 1);
        for (int i = 0; i <= 40; i++) begin sidx = i; step(1, 1, tri_pulse(i, 20, 300), 0, 0, 0); end
        chk("t1_qrs_count", q_count, 1);
        chk("t1_qrs_sample", q_idx, 26);
        chk("t1_max", q_max, 300);
        chk("t1_missed", q_miss, 0);
        chk("t1_rr", q_rr, 27);

        // 2: flat stream, forced beat on the 420th sample
        do_reset();
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 500; i++) begin sidx = i; step(1, 1, 10, 0, 0, 0); end
        chk("t2_qrs_sample", q_idx, 419);
        chk("t2_missed", q_miss, 1);
        chk("t2_max", q_max, 10);
        chk("t2_rr", q_rr, 420);
        chk("t2_class", q_cls, 0);

        // 3: second pulse inside the blanking window is ignored
        do_reset();
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 100; i++) begin
            sidx = i; step(1, 1, tri_pulse(i, 20, 300) + tri_pulse(i, 50, 300), 0, 0, 0);
        end
        chk("t3_qrs_count", q_count, 1);
        chk("t3_qrs_sample", q_idx, 26);

        // 4: beats every 210 samples with VF and AF both flagged
        do_reset();
        step(1, 0, 0, 0, 1, 1);
        for (int i = 0; i <= 700; i++) begin
            sidx = i;
            step(1, 1, tri_pulse(i, 20, 300) + tri_pulse(i, 230, 300) +
                       tri_pulse(i, 440, 300) + tri_pulse(i, 650, 300), 0, 1, 1);
            if (qrs) begin
                chk("t4_class_code", int'(class_code), 3);
                chk("t4_class_valid", int'(class_valid), 1);
                if (q_count >= 2) chk("t4_rr", int'(rr_interval), 210);
            end
        end
        chk("t4_qrs_count", q_count, 4);
        chk("t4_model_rr", m_rri, 210);

        // 5: sample_valid gaps inside the pulse do not change sample timing
        do_reset();
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i <= 40; i++) begin
            sidx = i; step(1, 1, tri_pulse(i, 20, 300), 0, 0, 0);
            if (i >= 21 && i <= 26) step(1, 0, int'($urandom_range(0, 999)), 0, 0, 0);
        end
        chk("t5_qrs_sample", q_idx, 26);
        chk("t5_rr", q_rr, 27);
        chk("t5_max", q_max, 300);

        // 6a: en dropped while in PEAK
        do_reset();
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i <= 234; i++) begin
            sidx = i; step(1, 1, tri_pulse(i, 20, 300) + tri_pulse(i, 230, 300), 1, 0, 0);
        end
        step(0, 1, 300, 1, 0, 0);
        chk("t6_en_qrs", int'(qrs), 0);
        chk("t6_en_start", int'(start), 0);
        repeat (3) step(0, 1, 300, 0, 0, 0);
        chk("t6_en_max_kept", int'($signed(max)), 300);
        chk("t6_en_rr_kept", int'(rr_interval), 27);
        chk("t6_en_cls_kept", int'(class_code), 1);

        // 6b: reset asserted on the edge that would launch a beat
        do_reset();
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i <= 235; i++) begin
            sidx = i; step(1, 1, tri_pulse(i, 20, 300) + tri_pulse(i, 230, 300), 0, 0, 0);
        end
        en = 1'b1; sample_valid = 1'b1; xin = DW'(240);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("t6_rst_qrs", int'(qrs), 0);
        chk("t6_rst_start", int'(start), 0);
        chk("t6_rst_max", int'($signed(max)), 100);
        chk("t6_rst_rr", int'(rr_interval), 0);
        model_reset();
        @(negedge clk);
        compare();
        rstn = 1'b1;

        // random traffic: noise, random pulses, sample gaps, en drops, resets
        pp = -1; pamp = 0; pw = 1; en_hold = 0;
        for (int c = 0; c < 30000; c++) begin
            if ($urandom_range(0, 4999) == 0) do_reset();
            e = 1'b1;
            if (en_hold > 0) begin e = 1'b0; en_hold--; end
            else if ($urandom_range(0, 1999) == 0) en_hold = int'($urandom_range(1, 3));
            v = ($urandom_range(0, 3) != 0);
            x = int'($urandom_range(0, 40)) - 20;
            if (pp < 0 && $urandom_range(0, 149) == 0) begin
                pp = 0; pamp = int'($urandom_range(100, 2000)); pw = int'($urandom_range(2, 8));
            end
            if (pp >= 0) begin
                x += pamp - (pamp * ((pp > pw) ? pp - pw : pw - pp)) / pw;
                if (v) pp++;
                if (pp > 2 * pw) pp = -1;
            end
            step(e, v, x, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
